// File: rtl/hazard_sched_unit_pkg.sv
// Shared definitions for the pipeline hazard scheduler: hazard op classes,
// forwarding select codes and the per-stage tracking entry.
package hazard_sched_unit_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_ALU   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_STORE = 2'd3
  } hz_optype_e;

  typedef enum logic [1:0] {
    FWD_RF       = 2'd0,
    FWD_EX_ALU   = 2'd1,
    FWD_MEM_ALU  = 2'd2,
    FWD_MEM_LOAD = 2'd3
  } fwd_sel_e;

  // rs2 rides along so a store in MEM can still see which register it wants.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    hz_optype_e        optype;
    logic [REG_AW-1:0] rs2;
  } stage_entry_t;

  localparam stage_entry_t BUBBLE = '{rd: '0, optype: OP_NONE, rs2: '0};

  function automatic logic produces_result(input hz_optype_e op);
    return (op == OP_ALU) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One tracked pipeline entry; a flush (or reset) loads a bubble instead of
// the upstream entry.
module hazard_stage_reg
  import hazard_sched_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  stage_entry_t i_entry,
  output stage_entry_t o_entry
);

  stage_entry_t r_entry;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_entry <= BUBBLE;
    end else begin
      r_entry <= i_entry;
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/hazard_sched_unit.sv
// Hazard scheduler for the 5-stage core: tracks EX/MEM/WB destinations,
// raises load-use stalls, redirect flushes and operand forwarding selects.
module hazard_sched_unit
  import hazard_sched_unit_pkg::*;
#(
  parameter int RA_W  = REG_AW,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  rs1_ID,
  input  logic [RA_W-1:0]  rs2_ID,
  input  logic [RA_W-1:0]  rd_ID,
  input  logic             rs1use_ID,
  input  logic             rs2use_ID,
  input  logic [1:0]       optype_ID,
  input  logic             Branch_ID,
  output logic             PC_EN_IF,
  output logic             reg_FD_EN,
  output logic             reg_FD_flush,
  output logic             reg_DE_flush,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic             fwd_ls,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int NSTG = 3;
  localparam int EX   = 0;
  localparam int MEM  = 1;
  localparam int WB   = 2;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  stage_entry_t     w_id_entry;
  stage_entry_t     w_stage_q [NSTG];
  logic             w_stall;
  logic             w_ex_load;
  fwd_sel_e         w_fwd_a;
  fwd_sel_e         w_fwd_b;
  logic             w_unused_wb_rs2;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_id_entry = '{rd: rd_ID, optype: hz_optype_e'(optype_ID), rs2: rs2_ID};

  // EX takes the ID entry (bubble on stall); older stages simply shift.
  generate
    for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        hazard_stage_reg u_stage (
          .clk     (clk),
          .rst     (rst),
          .i_flush (w_stall),
          .i_entry (w_id_entry),
          .o_entry (w_stage_q[gi])
        );
      end else begin : g_tail
        hazard_stage_reg u_stage (
          .clk     (clk),
          .rst     (rst),
          .i_flush (1'b0),
          .i_entry (w_stage_q[gi-1]),
          .o_entry (w_stage_q[gi])
        );
      end
    end
  endgenerate

  // A load into x0 writes nothing, so it can never create a load-use hazard.
  assign w_ex_load = (w_stage_q[EX].optype == OP_LOAD) && (w_stage_q[EX].rd != '0);
  assign w_stall   = ~rst & w_ex_load &
                     ((rs1use_ID & (rs1_ID == w_stage_q[EX].rd)) |
                      (rs2use_ID & (rs2_ID == w_stage_q[EX].rd) &
                       (w_id_entry.optype != OP_STORE)));

  // Youngest producer wins; a matching EX load shadows any older MEM value.
  function automatic fwd_sel_e fwd_pick(input logic [RA_W-1:0] rs,
                                        input stage_entry_t     ex,
                                        input stage_entry_t     mem);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (rs == '0) begin
      sel = FWD_RF;
    end else if ((rs == ex.rd) && produces_result(ex.optype)) begin
      if (ex.optype == OP_ALU) sel = FWD_EX_ALU;
      else                     sel = FWD_RF;
    end else if ((rs == mem.rd) && (mem.optype == OP_ALU)) begin
      sel = FWD_MEM_ALU;
    end else if ((rs == mem.rd) && (mem.optype == OP_LOAD)) begin
      sel = FWD_MEM_LOAD;
    end
    return sel;
  endfunction

  assign w_fwd_a = fwd_pick(rs1_ID, w_stage_q[EX], w_stage_q[MEM]);
  assign w_fwd_b = fwd_pick(rs2_ID, w_stage_q[EX], w_stage_q[MEM]);

  assign fwd_A = (rst || w_stall) ? 2'b00 : w_fwd_a;
  assign fwd_B = (rst || w_stall) ? 2'b00 : w_fwd_b;

  assign fwd_ls = ~rst &
                  (w_stage_q[MEM].optype == OP_STORE) &
                  (w_stage_q[WB].optype == OP_LOAD) &
                  (w_stage_q[WB].rd != '0) &
                  (w_stage_q[MEM].rs2 == w_stage_q[WB].rd);

  assign w_unused_wb_rs2 = ^w_stage_q[WB].rs2;

  assign PC_EN_IF     = ~w_stall;
  assign reg_FD_EN    = ~w_stall;
  assign reg_DE_flush = w_stall;
  assign reg_FD_flush = ~rst & Branch_ID & ~w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (reg_FD_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
